// File: rtl/gtp_pll_reconfig_ctrl.sv
// Reconfiguration sequencer for the GTP_PLL wrapper: gates outputs, loads new dividers,
// pulses PLL reset, qualifies lock with timeout/stability/retry, then ungates and monitors lock.
module gtp_pll_reconfig_ctrl #(
    parameter int unsigned        N_OUT        = 5,
    parameter int unsigned        INIT_IDIV    = 1,
    parameter int unsigned        INIT_FDIV    = 1,
    parameter logic [6*N_OUT-1:0] INIT_ODIV    = {N_OUT{6'd2}},
    parameter int unsigned        GATE_CYC     = 4,
    parameter int unsigned        RST_CYC      = 8,
    parameter int unsigned        LOCK_TIMEOUT = 1000,
    parameter int unsigned        LOCK_STABLE  = 64,
    parameter int unsigned        MAX_RETRY    = 3,
    parameter bit                 AUTO_RELOCK  = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               REQ_VALID,
    output logic               REQ_READY,
    input  logic [5:0]         REQ_IDIV,
    input  logic [5:0]         REQ_FDIV,
    input  logic [6*N_OUT-1:0] REQ_ODIV,
    input  logic               PLL_LOCK,
    output logic               PLL_RST,
    output logic [5:0]         DYN_IDIV,
    output logic [5:0]         DYN_FDIV,
    output logic [6*N_OUT-1:0] DYN_ODIV,
    output logic [N_OUT-1:0]   GATEO,
    output logic               BUSY,
    output logic               CLK_READY,
    output logic               ERR,
    output logic               LOCK_LOST,
    output logic [3:0]         RETRY_CNT
);

    localparam int unsigned MAX_A   = (LOCK_TIMEOUT > RST_CYC) ? LOCK_TIMEOUT : RST_CYC;
    localparam int unsigned MAX_B   = (GATE_CYC > LOCK_STABLE) ? GATE_CYC : LOCK_STABLE;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] GATE_LAST   = CW'(GATE_CYC - 1);
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
    localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

    // A divider of 64 is carried as 0 in the 6-bit field.
    localparam logic [5:0] INIT_IDIV_V = 6'(INIT_IDIV);
    localparam logic [5:0] INIT_FDIV_V = 6'(INIT_FDIV);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_UNGATE,
        ST_RUN,
        ST_GATE,
        ST_FAIL
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 lock_meta_q, lock_meta_d;
    logic                 lock_s_q, lock_s_d;
    logic [5:0]           idiv_q, idiv_d;
    logic [5:0]           fdiv_q, fdiv_d;
    logic [6*N_OUT-1:0]   odiv_q, odiv_d;
    logic [N_OUT-1:0]     gateo_q, gateo_d;
    logic                 pll_rst_q, pll_rst_d;
    logic                 req_ready_q, req_ready_d;
    logic                 busy_q, busy_d;
    logic                 clk_ready_q, clk_ready_d;
    logic                 err_q, err_d;
    logic                 lock_lost_q, lock_lost_d;
    logic [3:0]           retry_q, retry_d;
    logic                 accept;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_RESET;
            cnt_q       <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            idiv_q      <= INIT_IDIV_V;
            fdiv_q      <= INIT_FDIV_V;
            odiv_q      <= INIT_ODIV;
            gateo_q     <= '0;
            pll_rst_q   <= 1'b1;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            clk_ready_q <= 1'b0;
            err_q       <= 1'b0;
            lock_lost_q <= 1'b0;
            retry_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_meta_q <= lock_meta_d;
            lock_s_q    <= lock_s_d;
            idiv_q      <= idiv_d;
            fdiv_q      <= fdiv_d;
            odiv_q      <= odiv_d;
            gateo_q     <= gateo_d;
            pll_rst_q   <= pll_rst_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            clk_ready_q <= clk_ready_d;
            err_q       <= err_d;
            lock_lost_q <= lock_lost_d;
            retry_q     <= retry_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CW'(1);
        lock_meta_d = PLL_LOCK;
        lock_s_d    = lock_meta_q;
        idiv_d      = idiv_q;
        fdiv_d      = fdiv_q;
        odiv_d      = odiv_q;
        lock_lost_d = lock_lost_q;
        retry_d     = retry_q;
        accept      = REQ_VALID && req_ready_q;

        unique case (state_q)
            ST_RESET: begin
                if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = ST_STABLE;
                end else if (cnt_q == TO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 4'd1;
                        state_d = ST_RESET;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_STABLE: begin
                if (!lock_s_q)                 state_d = ST_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = ST_UNGATE;
            end
            ST_UNGATE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // A request wins over a lock drop seen in the same cycle.
                if (accept) begin
                    idiv_d      = REQ_IDIV;
                    fdiv_d      = REQ_FDIV;
                    odiv_d      = REQ_ODIV;
                    lock_lost_d = 1'b0;
                    retry_d     = '0;
                    state_d     = ST_GATE;
                end else if (!lock_s_q) begin
                    lock_lost_d = 1'b1;
                    retry_d     = '0;
                    state_d     = AUTO_RELOCK ? ST_RESET : ST_FAIL;
                end
            end
            ST_GATE: begin
                if (cnt_q == GATE_LAST) state_d = ST_RESET;
            end
            ST_FAIL: begin
                if (accept) begin
                    idiv_d      = REQ_IDIV;
                    fdiv_d      = REQ_FDIV;
                    odiv_d      = REQ_ODIV;
                    lock_lost_d = 1'b0;
                    retry_d     = '0;
                    state_d     = ST_GATE;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        if (state_d != state_q || state_q == ST_RUN || state_q == ST_FAIL) cnt_d = '0;

        // Outputs are registered from the next state so they track the state register.
        pll_rst_d   = (state_d == ST_RESET);
        gateo_d     = (state_d == ST_UNGATE || state_d == ST_RUN) ? '1 : '0;
        req_ready_d = (state_d == ST_RUN || state_d == ST_FAIL);
        busy_d      = !(state_d == ST_RUN || state_d == ST_FAIL);
        clk_ready_d = (state_d == ST_RUN);
        err_d       = (state_d == ST_FAIL);
    end

    assign REQ_READY = req_ready_q;
    assign PLL_RST   = pll_rst_q;
    assign DYN_IDIV  = idiv_q;
    assign DYN_FDIV  = fdiv_q;
    assign DYN_ODIV  = odiv_q;
    assign GATEO     = gateo_q;
    assign BUSY      = busy_q;
    assign CLK_READY = clk_ready_q;
    assign ERR       = err_q;
    assign LOCK_LOST = lock_lost_q;
    assign RETRY_CNT = retry_q;

endmodule

// File: tb/tb_gtp_pll_reconfig_ctrl.sv
// Scoreboard bench for gtp_pll_reconfig_ctrl with a behavioural PLL that locks 20 cycles
// after PLL_RST falls; lock can be suppressed or glitched by the bench.
module tb_gtp_pll_reconfig_ctrl;

    typedef struct packed {
        logic [5:0]  idiv;
        logic [5:0]  fdiv;
        logic [29:0] odiv;
    } dyn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_idiv, req_fdiv;
    logic [29:0] req_odiv;
    logic        pll_lock;
    logic        pll_rst;
    logic [5:0]  dyn_idiv, dyn_fdiv;
    logic [29:0] dyn_odiv;
    logic [4:0]  gateo;
    logic        busy, clk_ready, err, lock_lost;
    logic [3:0]  retry_cnt;

    logic        pll_model = 1'b0;
    int unsigned since_rst = 0;
    logic        kill_lock = 1'b0;
    logic        never_lock = 1'b0;

    int   checks = 0;
    int   errors = 0;
    dyn_t exp_q[$];

    localparam logic [29:0] INIT_ODIV_TB = {5{6'd2}};

    gtp_pll_reconfig_ctrl #(
        .LOCK_TIMEOUT(100),
        .MAX_RETRY   (2)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .REQ_VALID(req_valid),
        .REQ_READY(req_ready),
        .REQ_IDIV (req_idiv),
        .REQ_FDIV (req_fdiv),
        .REQ_ODIV (req_odiv),
        .PLL_LOCK (pll_lock),
        .PLL_RST  (pll_rst),
        .DYN_IDIV (dyn_idiv),
        .DYN_FDIV (dyn_fdiv),
        .DYN_ODIV (dyn_odiv),
        .GATEO    (gateo),
        .BUSY     (busy),
        .CLK_READY(clk_ready),
        .ERR      (err),
        .LOCK_LOST(lock_lost),
        .RETRY_CNT(retry_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pll_rst || never_lock) begin
            since_rst <= 0;
            pll_model <= 1'b0;
        end else if (since_rst < 20) begin
            since_rst <= since_rst + 1;
        end else begin
            pll_model <= 1'b1;
        end
    end

    assign pll_lock = pll_model & ~kill_lock;

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic send_request(input logic [5:0] i, input logic [5:0] f,
                                input logic [29:0] o, output bit ok);
        exp_q.push_back('{idiv: i, fdiv: f, odiv: o});
        req_idiv  = i;
        req_fdiv  = f;
        req_odiv  = o;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            if (req_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(negedge clk);
        end else begin
            req_valid = 1'b0;
        end
    endtask

    // Returns on the first negedge with PLL_RST low after a high phase of hi negedges.
    task automatic wait_rst_fall(output int hi, output bit ok);
        for (int n = 0; n < 3000 && !pll_rst; n++) @(negedge clk);
        hi = 0;
        while (pll_rst && hi < 200) begin
            hi++;
            @(negedge clk);
        end
        ok = (!pll_rst && hi > 0);
    endtask

    task automatic wait_ready(input int start, input int budget, output int lat, output bit ok);
        lat = start;
        while (!clk_ready && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        ok = clk_ready;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0;
        req_idiv = '0;
        req_fdiv = '0;
        req_odiv = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({pll_rst, gateo, req_ready, busy, clk_ready, err, lock_lost, retry_cnt} !==
            {1'b1, 5'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_ctrl got rst=%b gateo=%h rdy=%b busy=%b crdy=%b err=%b ll=%b rc=%0d want 1 00 0 1 0 0 0 0",
                     pll_rst, gateo, req_ready, busy, clk_ready, err, lock_lost, retry_cnt);
        end
        checks++;
        if ({dyn_idiv, dyn_fdiv, dyn_odiv} !== {6'd1, 6'd1, INIT_ODIV_TB}) begin
            errors++;
            $display("FAIL reset_dyn got %h/%h/%h want 01/01/%h", dyn_idiv, dyn_fdiv, dyn_odiv, INIT_ODIV_TB);
        end
    endtask

    task automatic test_power_up;
        int hi, lat;
        bit ok;
        rst = 1'b0;
        wait_rst_fall(hi, ok);
        checks++;
        if (!ok || hi != 8) begin
            errors++;
            $display("FAIL powerup_rst_len got %0d (ok=%b) want 8", hi, ok);
        end
        wait_ready(1, 400, lat, ok);
        checks++;
        if (!ok || lat < 86 || lat > 92) begin
            errors++;
            $display("FAIL powerup_ready_lat got %0d (ok=%b) want 86..92", lat, ok);
        end
        checks++;
        if ({gateo, pll_rst, busy, req_ready} !== {5'h1F, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL powerup_run got gateo=%h rst=%b busy=%b rdy=%b want 1f 0 0 1", gateo, pll_rst, busy, req_ready);
        end
    endtask

    task automatic test_reconfig;
        int hi, lat, gn;
        bit ok;
        dyn_t e;
        send_request(6'd2, 6'd10, {6'd2, 6'd2, 6'd2, 6'd2, 6'd4}, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reconfig_accept got timeout want accept");
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL reconfig_dyn got empty scoreboard want entry");
        end else begin
            e = exp_q.pop_front();
            if ({dyn_idiv, dyn_fdiv, dyn_odiv} !== e) begin
                errors++;
                $display("FAIL reconfig_dyn got %h want %h", {dyn_idiv, dyn_fdiv, dyn_odiv}, e);
            end
        end
        checks++;
        if ({gateo, req_ready, clk_ready, busy} !== {5'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reconfig_gate got gateo=%h rdy=%b crdy=%b busy=%b want 00 0 0 1", gateo, req_ready, clk_ready, busy);
        end
        gn = 0;
        while (!pll_rst && gn < 50) begin
            if (gateo != 5'h00) gn = 100;
            gn++;
            @(negedge clk);
        end
        checks++;
        if (gn != 4) begin
            errors++;
            $display("FAIL reconfig_gate_len got %0d want 4", gn);
        end
        wait_rst_fall(hi, ok);
        checks++;
        if (!ok || hi != 8) begin
            errors++;
            $display("FAIL reconfig_rst_len got %0d (ok=%b) want 8", hi, ok);
        end
        wait_ready(1, 400, lat, ok);
        checks++;
        if (!ok || lat < 86 || lat > 92 || gateo !== 5'h1F) begin
            errors++;
            $display("FAIL reconfig_relock got lat=%0d ok=%b gateo=%h want 86..92 1 1f", lat, ok, gateo);
        end
    endtask

    task automatic test_lock_glitch;
        int hi, lat;
        bit ok;
        dyn_t e;
        send_request(6'd3, 6'd12, {6'd7, 6'd6, 6'd5, 6'd4, 6'd3}, ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++;
            $display("FAIL glitch_accept got ok=%b q=%0d want 1 >0", ok, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({dyn_idiv, dyn_fdiv, dyn_odiv} !== e) begin
                errors++;
                $display("FAIL glitch_dyn got %h want %h", {dyn_idiv, dyn_fdiv, dyn_odiv}, e);
            end
        end
        wait_rst_fall(hi, ok);
        repeat (53) @(negedge clk);
        kill_lock = 1'b1;
        @(negedge clk);
        kill_lock = 1'b0;
        wait_ready(55, 500, lat, ok);
        checks++;
        if (!ok || lat < 118 || lat > 128) begin
            errors++;
            $display("FAIL glitch_restart_lat got %0d (ok=%b) want 118..128", lat, ok);
        end
    endtask

    task automatic test_lock_drop;
        int hi, lat, n;
        bit ok;
        @(negedge clk);
        kill_lock = 1'b1;
        n = 0;
        while (gateo != 5'h00 && n < 6) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ({gateo, lock_lost, clk_ready, pll_rst, req_ready, retry_cnt} !==
            {5'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL drop_react got gateo=%h ll=%b crdy=%b rst=%b rdy=%b rc=%0d want 00 1 0 1 0 0",
                     gateo, lock_lost, clk_ready, pll_rst, req_ready, retry_cnt);
        end
        kill_lock = 1'b0;
        wait_rst_fall(hi, ok);
        checks++;
        if (!ok || hi != 8) begin
            errors++;
            $display("FAIL drop_rst_len got %0d (ok=%b) want 8", hi, ok);
        end
        wait_ready(1, 400, lat, ok);
        checks++;
        if (!ok || lat < 86 || lat > 92 || lock_lost !== 1'b1) begin
            errors++;
            $display("FAIL drop_recover got lat=%0d ok=%b ll=%b want 86..92 1 1", lat, ok, lock_lost);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        bit ok;
        dyn_t e;
        send_request(6'd5, 6'd20, {6'd8, 6'd8, 6'd8, 6'd8, 6'd8}, ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_a_accept got ok=%b q=%0d want 1 >0", ok, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({dyn_idiv, dyn_fdiv, dyn_odiv, lock_lost} !== {e, 1'b0}) begin
                errors++;
                $display("FAIL b2b_a_dyn got %h ll=%b want %h ll=0", {dyn_idiv, dyn_fdiv, dyn_odiv}, lock_lost, e);
            end
        end
        wait_ready(1, 600, lat, ok);
        send_request(6'd63, 6'd0, {6'd1, 6'd2, 6'd3, 6'd4, 6'd63}, ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++;
            $display("FAIL b2b_b_accept got ok=%b q=%0d want 1 >0", ok, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({dyn_idiv, dyn_fdiv, dyn_odiv} !== e) begin
                errors++;
                $display("FAIL b2b_b_dyn got %h want %h", {dyn_idiv, dyn_fdiv, dyn_odiv}, e);
            end
        end
        // A request held while busy must not disturb the dividers.
        req_idiv  = 6'd9;
        req_fdiv  = 6'd9;
        req_odiv  = {5{6'd9}};
        req_valid = 1'b1;
        repeat (20) @(negedge clk);
        req_valid = 1'b0;
        wait_ready(21, 600, lat, ok);
        checks++;
        if (!ok || {dyn_idiv, dyn_fdiv, dyn_odiv} !== e) begin
            errors++;
            $display("FAIL b2b_ignore_busy got ok=%b dyn=%h want 1 %h", ok, {dyn_idiv, dyn_fdiv, dyn_odiv}, e);
        end
    endtask

    task automatic test_retry_fail;
        int rises, lat;
        bit ok, prev;
        dyn_t e;
        never_lock = 1'b1;
        send_request(6'd4, 6'd16, {6'd3, 6'd3, 6'd3, 6'd3, 6'd3}, ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++;
            $display("FAIL retry_accept got ok=%b q=%0d want 1 >0", ok, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({dyn_idiv, dyn_fdiv, dyn_odiv} !== e) begin
                errors++;
                $display("FAIL retry_dyn got %h want %h", {dyn_idiv, dyn_fdiv, dyn_odiv}, e);
            end
        end
        rises = 0;
        prev = pll_rst;
        for (int n = 0; n < 2000 && !err; n++) begin
            @(negedge clk);
            if (pll_rst && !prev) rises++;
            prev = pll_rst;
        end
        checks++;
        if (rises != 3 || retry_cnt !== 4'd2) begin
            errors++;
            $display("FAIL retry_count got pulses=%0d rc=%0d want 3 2", rises, retry_cnt);
        end
        checks++;
        if ({err, req_ready, busy, pll_rst, gateo, clk_ready} !== {1'b1, 1'b1, 1'b0, 1'b0, 5'h00, 1'b0}) begin
            errors++;
            $display("FAIL fail_state got err=%b rdy=%b busy=%b rst=%b gateo=%h crdy=%b want 1 1 0 0 00 0",
                     err, req_ready, busy, pll_rst, gateo, clk_ready);
        end
        never_lock = 1'b0;
        send_request(6'd1, 6'd1, {6'd2, 6'd2, 6'd2, 6'd2, 6'd2}, ok);
        checks++;
        if (!ok || exp_q.size() == 0) begin
            errors++;
            $display("FAIL fail_recover_accept got ok=%b q=%0d want 1 >0", ok, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({dyn_idiv, dyn_fdiv, dyn_odiv, err, retry_cnt, busy} !== {e, 1'b0, 4'h0, 1'b1}) begin
                errors++;
                $display("FAIL fail_clear got dyn=%h err=%b rc=%0d busy=%b want %h 0 0 1",
                         {dyn_idiv, dyn_fdiv, dyn_odiv}, err, retry_cnt, busy, e);
            end
        end
        wait_ready(1, 600, lat, ok);
        checks++;
        if (!ok || err !== 1'b0) begin
            errors++;
            $display("FAIL fail_relock got ok=%b err=%b want 1 0", ok, err);
        end
    endtask

    task automatic test_reset_mid_sequence;
        int hi, lat;
        bit ok, bad;
        dyn_t e;
        send_request(6'd6, 6'd30, {6'd5, 6'd5, 6'd5, 6'd5, 6'd5}, ok);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        wait_rst_fall(hi, ok);
        exp_q.push_back('{idiv: 6'd11, fdiv: 6'd22, odiv: {5{6'd33}}});
        req_idiv  = 6'd11;
        req_fdiv  = 6'd22;
        req_odiv  = {5{6'd33}};
        req_valid = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({pll_rst, gateo, req_ready, busy, clk_ready, err, lock_lost, retry_cnt, dyn_idiv, dyn_fdiv, dyn_odiv} !==
            {1'b1, 5'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 6'd1, 6'd1, INIT_ODIV_TB}) begin
            errors++;
            $display("FAIL midreset_values got rst=%b gateo=%h rdy=%b busy=%b dyn=%h want 1 00 0 1 %h",
                     pll_rst, gateo, req_ready, busy, {dyn_idiv, dyn_fdiv, dyn_odiv}, {6'd1, 6'd1, INIT_ODIV_TB});
        end
        rst = 1'b0;
        wait_rst_fall(hi, ok);
        checks++;
        if (!ok || hi != 8) begin
            errors++;
            $display("FAIL midreset_rst_len got %0d (ok=%b) want 8", hi, ok);
        end
        bad = 1'b0;
        lat = 1;
        while (!clk_ready && lat < 400) begin
            if (req_ready || {dyn_idiv, dyn_fdiv, dyn_odiv} != {6'd1, 6'd1, INIT_ODIV_TB}) bad = 1'b1;
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!clk_ready || bad) begin
            errors++;
            $display("FAIL midreset_req_ignored got ready=%b disturbed=%b want 1 0", clk_ready, bad);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL midreset_accept got empty scoreboard want entry");
        end else begin
            e = exp_q.pop_front();
            if ({dyn_idiv, dyn_fdiv, dyn_odiv, gateo} !== {e, 5'h00}) begin
                errors++;
                $display("FAIL midreset_accept got %h gateo=%h want %h 00", {dyn_idiv, dyn_fdiv, dyn_odiv}, gateo, e);
            end
        end
    endtask

    initial begin
        test_reset;
        test_power_up;
        test_reconfig;
        test_lock_glitch;
        test_lock_drop;
        test_back_to_back;
        test_retry_fail;
        test_reset_mid_sequence;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
